ksa_pipe_nbit: RTL and testbench
================================

Name: ksa_pipe_nbit

Overview:
- Parametrised, pipelined successor to the combinational N-bit Kogge-Stone adder.
- Computes S = A + B + Ci (add) or S = A + ~B + Ci (subtract) with carry-out and signed overflow.
- Pipeline registers sit between groups of prefix levels, and a valid/ready handshake runs on both sides.
- Serves as the drop-in arithmetic core for clocked datapaths, where the flat N-bit adder does not meet timing at wide N.

Parameters:
- N, 16, operand/sum width; any value >= 2.
- STAGE_EVERY, 1, number of prefix levels between pipeline registers; legal range 1..LOG2N.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- A  input  N  operand A.
- B  input  N  operand B.
- Ci  input  1  carry-in.
- SUB  input  1  0: A+B+Ci; 1: A+~B+Ci. Ci=1 with SUB=1 gives A-B.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- S  output  N  sum.
- Co  output  1  carry out of the MSB.
- OV  output  1  signed overflow: carry into MSB XOR Co.

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low.
- Derived constants:
  - LOG2N = clog2(N).
  - NGRP = ceil(LOG2N/STAGE_EVERY).
  - LAT = NGRP + 1.
- Stage 0:
  - Forms Beff = B XOR {N{SUB}}.
  - Computes bitwise G = A&Beff and P = A^Beff.
  - Folds Ci in as the bit -1 generate.
  - Registers G, P, the original P for the sum, and valid.
- Prefix levels: level k (k = 0..LOG2N-1) combines spans at distance 2^k.
  - Black cell: G' = Gi | Pi&Gj, P' = Pi&Pj.
  - Grey cell where j reaches bit -1.
  - Pass-through where j < -1.
  - A register follows every STAGE_EVERY levels, and always follows the last level group.
- Final stage:
  - S[i] = Porig[i] ^ Cin[i], where Cin[0] = Ci and Cin[i] = Gprefix[i-1].
  - Co = Gprefix[N-1].
  - OV = Cin[N-1] ^ Co.
  - S, Co and OV are taken straight from registers; no combinational path from inputs to outputs.
- Latency: a beat accepted on edge t (in_valid & in_ready) shows out_valid=1 with its result after edge t+LAT. No stall means LAT = 5 for N=16, STAGE_EVERY=1.
- Throughput: one beat per cycle while out_ready=1.
- Flow control: global pipeline enable adv = ~out_valid | out_ready.
  - in_ready = adv, combinational.
  - When adv=0, every stage register holds its value, and S/Co/OV/out_valid stay stable.
  - Bubbles are not collapsed.
  - in_valid=0 while adv=1 inserts a bubble: stage valid=0.
  - A result must not change while out_valid=1 and out_ready=0.
- Simultaneous events: out_valid=1, out_ready=1 and in_valid=1 in one cycle gives both transfers and a full advance.
- Reset (rst_n=0 at an edge):
  - All stage valid bits go to 0.
  - out_valid=0, S=0, Co=0, OV=0.
  - All data registers go to 0.
  - in_ready=1 from the first cycle after reset.
  - In-flight beats are discarded; none emerges after reset.
  - Reset overrides a simultaneous stall or transfer.
- Width: no operand sign extension. Modular N-bit result; Co is the (N+1)th bit of A+Beff+Ci.
- N not a power of two: the prefix tree uses LOG2N levels with edge pass-through. Results must still be exact.

Decomposition:
- Package ksa_pkg:
  - clog2 constant function.
  - Helpers for LOG2N, NGRP and LAT.
  - Black/grey cell functions.
- Sub-module ksa_prefix_level (params N, DIST): one combinational Kogge-Stone level.
  - Instantiated LOG2N times by generate.
  - The parent inserts the registers and valid bits between levels.

Test Plan:
1. N=16, SE=1, out_ready=1; A=FFFF, B=0001, Ci=1, SUB=0 -> 5 cycles later out_valid=1, S=0001, Co=1, OV=0.
2. Back-to-back, 4 consecutive beats, results on 4 consecutive cycles in order starting at +5:
   - FFFF+0019+1 -> S=0019, Co=1.
   - 0019+0019+0 -> S=0032, Co=0.
   - FFFF+0007+1 -> S=0007, Co=1.
   - FFFF+0001+0 -> S=0000, Co=1.
3. Subtract, Ci=1, SUB=1:
   - 0005-0007 -> S=FFFE, Co=0, OV=0.
   - 8000-0001 -> S=7FFF, Co=1, OV=1.
   - 7FFF-FFFF -> S=8000, Co=0, OV=1.
4. Backpressure: drop out_ready for 3 cycles while the pipe is full.
   - in_ready=0 throughout.
   - S/Co/OV held stable.
   - On release, all results emerge in order; no loss or duplication.
   - A scoreboard counts accepted beats == delivered beats.
5. Reset mid-operation: 3 beats in flight, rst_n=0 for 1 cycle.
   - Next cycle: out_valid=0, S=0, Co=0, OV=0, in_ready=1.
   - No stale result appears over the following LAT+2 cycles.
6. Parameter sweep, 10k random beats each (random in_valid/out_ready), all results vs a behavioural A+Beff+Ci model:
   - N=8, SE=3 (LAT=2).
   - N=32, SE=2 (LAT=4).
   - N=12, SE=1 (LAT=5).

Source files
------------

// File: rtl/ksa_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | ksa_pkg: shared sizing helpers and prefix-cell functions for ksa_pipe_nbit  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package ksa_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int ksa_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int ksa_log2n(input int n);
        return ksa_clog2(n);
    endfunction

    function automatic int ksa_ngrp(input int n, input int se);
        return (ksa_log2n(n) + se - 1) / se;
    endfunction

    function automatic int ksa_lat(input int n, input int se);
        return ksa_ngrp(n, se) + 1;
    endfunction

    function automatic gp_t ksa_black(input logic gi, input logic pi,
                                      input logic gj, input logic pj);
        gp_t r;
        r.g = gi | (pi & gj);
        r.p = pi & pj;
        return r;
    endfunction

    function automatic logic ksa_grey(input logic gi, input logic pi,
                                      input logic gj);
        return gi | (pi & gj);
    endfunction

endpackage : ksa_pkg
`default_nettype wire

// File: rtl/ksa_prefix_level.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | ksa_prefix_level: one combinational Kogge-Stone level at span distance DIST |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module ksa_prefix_level
    import ksa_pkg::*;
#(
    parameter int N    = 16,
    parameter int DIST = 1
) (
    input  logic [N-1:0] g_i,
    input  logic [N-1:0] p_i,
    output logic [N-1:0] g_o,
    output logic [N-1:0] p_o
);

    for (genvar i = 0; i < N; i++) begin : g_bit
        if (i < DIST) begin : g_pass
            assign g_o[i] = g_i[i];
            assign p_o[i] = p_i[i];
        end else if (i < 2 * DIST) begin : g_grey
            // Partner span already reaches the carry-in, so the group propagate is 0.
            assign g_o[i] = ksa_grey(g_i[i], p_i[i], g_i[i-DIST]);
            assign p_o[i] = 1'b0;
        end else begin : g_black
            gp_t w_c;
            assign w_c    = ksa_black(g_i[i], p_i[i], g_i[i-DIST], p_i[i-DIST]);
            assign g_o[i] = w_c.g;
            assign p_o[i] = w_c.p;
        end
    end

endmodule : ksa_prefix_level
`default_nettype wire

// File: rtl/ksa_pipe_nbit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | ksa_pipe_nbit: pipelined N-bit Kogge-Stone add/sub with valid/ready flow    |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module ksa_pipe_nbit
    import ksa_pkg::*;
#(
    parameter int N           = 16,
    parameter int STAGE_EVERY = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Ci,
    input  logic         SUB,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] S,
    output logic         Co,
    output logic         OV
);

    localparam int LOG2N = ksa_log2n(N);
    localparam int NGRP  = ksa_ngrp(N, STAGE_EVERY);

    // Register slot 0 is the operand stage; slot g+1 closes prefix group g.
    logic [N-1:0] g_q  [0:NGRP];
    logic [N-1:0] g_d  [0:NGRP];
    logic [N-1:0] p_q  [0:NGRP];
    logic [N-1:0] p_d  [0:NGRP];
    logic [N-1:0] po_q [0:NGRP];
    logic [N-1:0] po_d [0:NGRP];
    logic         ci_q [0:NGRP];
    logic         ci_d [0:NGRP];
    logic         v_q  [0:NGRP];
    logic         v_d  [0:NGRP];

    logic [N-1:0] w_lvl_gi [0:LOG2N-1];
    logic [N-1:0] w_lvl_pi [0:LOG2N-1];
    logic [N-1:0] w_lvl_go [0:LOG2N-1];
    logic [N-1:0] w_lvl_po [0:LOG2N-1];

    logic [N-1:0] s_q;
    logic [N-1:0] s_d;
    logic         co_q;
    logic         co_d;
    logic         ov_q;
    logic         ov_d;
    logic         ovld_q;

    logic         w_adv;
    logic [N-1:0] w_beff;
    logic [N-1:0] w_g0;
    logic [N-1:0] w_p0;
    logic [N-1:0] w_cin;

    assign w_adv    = ~ovld_q | out_ready;
    assign in_ready = w_adv;

    assign w_beff = B ^ {N{SUB}};
    assign w_p0   = A ^ w_beff;
    assign w_g0   = A & w_beff;

    // Carry-in is absorbed into bit 0 so LOG2N levels cover every span.
    assign g_d[0]  = {w_g0[N-1:1], w_g0[0] | (w_p0[0] & Ci)};
    assign p_d[0]  = {w_p0[N-1:1], 1'b0};
    assign po_d[0] = w_p0;
    assign ci_d[0] = Ci;
    assign v_d[0]  = in_valid;

    for (genvar k = 0; k < LOG2N; k++) begin : g_lvl
        if (k % STAGE_EVERY == 0) begin : g_from_reg
            assign w_lvl_gi[k] = g_q[k/STAGE_EVERY];
            assign w_lvl_pi[k] = p_q[k/STAGE_EVERY];
        end else begin : g_from_lvl
            assign w_lvl_gi[k] = w_lvl_go[k-1];
            assign w_lvl_pi[k] = w_lvl_po[k-1];
        end

        ksa_prefix_level #(
            .N    (N),
            .DIST (1 << k)
        ) u_level (
            .g_i (w_lvl_gi[k]),
            .p_i (w_lvl_pi[k]),
            .g_o (w_lvl_go[k]),
            .p_o (w_lvl_po[k])
        );
    end

    for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
        localparam int LAST = (((gi + 1) * STAGE_EVERY < LOG2N) ?
                               (gi + 1) * STAGE_EVERY : LOG2N) - 1;
        assign g_d[gi+1]  = w_lvl_go[LAST];
        assign p_d[gi+1]  = w_lvl_po[LAST];
        assign po_d[gi+1] = po_q[gi];
        assign ci_d[gi+1] = ci_q[gi];
        assign v_d[gi+1]  = v_q[gi];
    end

    assign w_cin = {g_q[NGRP][N-2:0], ci_q[NGRP]};
    assign s_d   = po_q[NGRP] ^ w_cin;
    assign co_d  = g_q[NGRP][N-1];
    assign ov_d  = w_cin[N-1] ^ co_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i <= NGRP; i++) begin
                g_q[i]  <= '0;
                p_q[i]  <= '0;
                po_q[i] <= '0;
                ci_q[i] <= 1'b0;
                v_q[i]  <= 1'b0;
            end
            s_q    <= '0;
            co_q   <= 1'b0;
            ov_q   <= 1'b0;
            ovld_q <= 1'b0;
        end else if (w_adv) begin
            for (int i = 0; i <= NGRP; i++) begin
                g_q[i]  <= g_d[i];
                p_q[i]  <= p_d[i];
                po_q[i] <= po_d[i];
                ci_q[i] <= ci_d[i];
                v_q[i]  <= v_d[i];
            end
            s_q    <= s_d;
            co_q   <= co_d;
            ov_q   <= ov_d;
            ovld_q <= v_q[NGRP];
        end
    end

    assign out_valid = ovld_q;
    assign S         = s_q;
    assign Co        = co_q;
    assign OV        = ov_q;

endmodule : ksa_pipe_nbit
`default_nettype wire

// File: tb/tb_ksa_pipe_nbit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_ksa_pipe_nbit: directed N=16 checks plus random sweeps at other widths   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_ksa_pipe_nbit;

    localparam int LAT = 5;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, in_ready, ci, sub, out_valid, out_ready, co, ov;
    logic [15:0] a, b, s;

    int total = 0;
    int bad   = 0;
    int acc   = 0;
    int dlv   = 0;

    logic [15:0] ba [8];
    logic [15:0] bb [8];
    logic [15:0] es [8];
    logic        bci [8];
    logic        bsub [8];
    logic        eco [8];
    logic        eov [8];

    ksa_pipe_nbit #(.N(16), .STAGE_EVERY(1)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .Ci        (ci),
        .SUB       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (s),
        .Co        (co),
        .OV        (ov)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int i, input logic [15:0] va, input logic [15:0] vb,
                            input logic vci, input logic vsub, input logic [15:0] vs,
                            input logic vco, input logic vov);
        ba[i] = va; bb[i] = vb; bci[i] = vci; bsub[i] = vsub;
        es[i] = vs; eco[i] = vco; eov[i] = vov;
    endtask

    task automatic drive(input int i);
        in_valid = 1'b1;
        a = ba[i]; b = bb[i]; ci = bci[i]; sub = bsub[i];
    endtask

    // Back-to-back beats with out_ready held high; checks exact latency and order.
    task automatic burst(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            drive(i);
            tick();
        end
        in_valid = 1'b0;
        for (int e = n; e < LAT + n; e++) begin
            tick();
            if (e < LAT)
                check({tag, "_lat"}, out_valid, 1'b0);
            else
                check($sformatf("%s_r%0d", tag, e - LAT), {out_valid, co, ov, s},
                      {1'b1, eco[e-LAT], eov[e-LAT], es[e-LAT]});
        end
        tick();
        check({tag, "_tail"}, out_valid, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) acc++;
            if (out_valid && out_ready) dlv++;
        end
    end

    // Random sweep at other widths/stage spacings against a behavioural model.
    logic        sw_rst_n, sw_in_valid, sw_out_ready, sw_ci, sw_sub;
    logic [31:0] sw_a, sw_b;

    for (genvar gi = 0; gi < 3; gi++) begin : g_sw
        localparam int NN = (gi == 0) ? 8 : (gi == 1) ? 32 : 12;
        localparam int SE = (gi == 0) ? 3 : (gi == 1) ? 2 : 1;

        logic [NN-1:0] s_o;
        logic          in_rdy, out_vld, co_o, ov_o;
        logic [NN+1:0] q [$];
        int            acc_n = 0;
        int            dlv_n = 0;
        logic [NN-1:0] ma, mbe;
        logic [NN:0]   msum;
        logic [NN+1:0] mexp;

        ksa_pipe_nbit #(.N(NN), .STAGE_EVERY(SE)) u_dut (
            .clk       (clk),
            .rst_n     (sw_rst_n),
            .in_valid  (sw_in_valid),
            .in_ready  (in_rdy),
            .A         (sw_a[NN-1:0]),
            .B         (sw_b[NN-1:0]),
            .Ci        (sw_ci),
            .SUB       (sw_sub),
            .out_valid (out_vld),
            .out_ready (sw_out_ready),
            .S         (s_o),
            .Co        (co_o),
            .OV        (ov_o)
        );

        always @(negedge clk) begin
            if (sw_rst_n) begin
                if (sw_in_valid && in_rdy) begin
                    ma   = sw_a[NN-1:0];
                    mbe  = sw_sub ? ~sw_b[NN-1:0] : sw_b[NN-1:0];
                    msum = {1'b0, ma} + {1'b0, mbe} + {{NN{1'b0}}, sw_ci};
                    q.push_back({msum[NN],
                                 (ma[NN-1] == mbe[NN-1]) && (msum[NN-1] != ma[NN-1]),
                                 msum[NN-1:0]});
                    acc_n++;
                end
                if (out_vld && sw_out_ready) begin
                    dlv_n++;
                    if (q.size() == 0) begin
                        check($sformatf("sw%0d_extra", NN), 1'b1, 1'b0);
                    end else begin
                        mexp = q.pop_front();
                        check($sformatf("sw%0d_res", NN), {co_o, ov_o, s_o}, mexp);
                    end
                end
            end
        end
    end

    initial begin
        int acc0, dlv0;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0; out_ready = 1'b1;
        sw_rst_n = 1'b0; sw_in_valid = 1'b0; sw_out_ready = 1'b1;
        sw_a = '0; sw_b = '0; sw_ci = 1'b0; sw_sub = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        sw_rst_n = 1'b1;
        check("rst_out", {out_valid, co, ov, s}, 19'h0);
        check("rst_rdy", in_ready, 1'b1);

        // Single beat: FFFF + 0001 + 1
        set_beat(0, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);
        burst(1, "t1");

        // Four back-to-back beats
        set_beat(0, 16'hFFFF, 16'h0019, 1'b1, 1'b0, 16'h0019, 1'b1, 1'b0);
        set_beat(1, 16'h0019, 16'h0019, 1'b0, 1'b0, 16'h0032, 1'b0, 1'b0);
        set_beat(2, 16'hFFFF, 16'h0007, 1'b1, 1'b0, 16'h0007, 1'b1, 1'b0);
        set_beat(3, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        burst(4, "t2");

        // Subtract with Ci=1
        set_beat(0, 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        set_beat(1, 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        set_beat(2, 16'h7FFF, 16'hFFFF, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1);
        burst(3, "t3");

        // Backpressure with a full pipe
        set_beat(0, 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);
        set_beat(1, 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
        set_beat(2, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0);
        set_beat(3, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        set_beat(4, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        acc0 = acc;
        dlv0 = dlv;
        for (int i = 0; i < 5; i++) begin
            drive(i);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        check("bp_first", {out_valid, co, ov, s}, {1'b1, eco[0], eov[0], es[0]});
        for (int c = 0; c < 3; c++) begin
            check("bp_inrdy", in_ready, 1'b0);
            tick();
            check("bp_hold", {out_valid, co, ov, s}, {1'b1, eco[0], eov[0], es[0]});
        end
        out_ready = 1'b1;
        #1;
        check("bp_rel_rdy", in_ready, 1'b1);
        for (int i = 1; i < 5; i++) begin
            tick();
            check($sformatf("bp_r%0d", i), {out_valid, co, ov, s},
                  {1'b1, eco[i], eov[i], es[i]});
        end
        tick();
        check("bp_tail", out_valid, 1'b0);
        check("bp_acc", acc - acc0, 5);
        check("bp_count", dlv - dlv0, acc - acc0);

        // Reset with beats in flight, overriding a stall and an offered beat
        for (int i = 0; i < 6; i++) begin
            drive(i % 5);
            tick();
        end
        check("rst_pre", {out_valid, s}, {1'b1, es[0]});
        rst_n = 1'b0;
        out_ready = 1'b0;
        drive(1);
        tick();
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("rst2_out", {out_valid, co, ov, s}, 19'h0);
        check("rst2_rdy", in_ready, 1'b1);
        for (int c = 0; c < LAT + 2; c++) begin
            tick();
            check("rst2_stale", out_valid, 1'b0);
        end

        // Random sweep
        for (int c = 0; c < 10000; c++) begin
            sw_in_valid  = ($urandom_range(0, 3) != 0);
            sw_out_ready = ($urandom_range(0, 3) != 0);
            sw_a   = $urandom;
            sw_b   = $urandom;
            sw_ci  = $urandom_range(0, 1) != 0;
            sw_sub = $urandom_range(0, 1) != 0;
            tick();
        end
        sw_in_valid  = 1'b0;
        sw_out_ready = 1'b1;
        repeat (12) tick();
        check("sw8_count",  g_sw[0].dlv_n, g_sw[0].acc_n);
        check("sw32_count", g_sw[1].dlv_n, g_sw[1].acc_n);
        check("sw12_count", g_sw[2].dlv_n, g_sw[2].acc_n);
        check("sw8_busy",  g_sw[0].acc_n > 1000, 1'b1);
        check("sw32_busy", g_sw[1].acc_n > 1000, 1'b1);
        check("sw12_busy", g_sw[2].acc_n > 1000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ksa_pipe_nbit
`default_nettype wire
